// File: rtl/pu_attr_pkg.sv
// rtl/pu_attr_pkg.sv - shared bus attribute definitions for processing units
package pu_attr_pkg;

    // Default bus geometry shared by the PUs on the data/attribute bus
    localparam int PU_DATA_WIDTH = 16;
    localparam int PU_ATTR_WIDTH = 2;

    // Attribute bit positions
    localparam int ATTR_INVALID  = 0;
    localparam int ATTR_OVERFLOW = 1;

    // Values a PU drives when it is not driving, so outputs can be OR-combined
    localparam logic [PU_DATA_WIDTH-1:0] PU_DATA_ZERO = '0;
    localparam logic [PU_ATTR_WIDTH-1:0] PU_ATTR_ZERO = '0;

    // Attribute word carrying only the invalid marker
    localparam logic [PU_ATTR_WIDTH-1:0] PU_ATTR_INVALID_WORD = PU_ATTR_WIDTH'(1 << ATTR_INVALID);

endpackage

// File: rtl/pu_fifo_mem.sv
// rtl/pu_fifo_mem.sv - FIFO storage array, one sync write port, one async read port
module pu_fifo_mem #(
    parameter int WIDTH      = 18,
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [WIDTH-1:0]      wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [WIDTH-1:0]      rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Storage has no reset; only entries between the pointers are ever read as data
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/pu_fifo.sv
// rtl/pu_fifo.sv - bus-side FIFO processing unit replaying captured bus words
module pu_fifo
    import pu_attr_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ATTR_WIDTH = 2,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  signal_wr,
    input  logic                  signal_oe,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [ATTR_WIDTH-1:0] attr_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [ATTR_WIDTH-1:0] attr_out,
    output logic                  flag_empty,
    output logic                  flag_full,
    output logic                  flag_err
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = DATA_WIDTH + ATTR_WIDTH;

    logic [AW-1:0]         wptr;
    logic [AW-1:0]         rptr;
    logic [CW-1:0]         count;
    logic [CW-1:0]         count_next;
    logic                  is_empty;
    logic                  is_full;
    logic                  do_push;
    logic                  do_pop;
    logic                  underflow;
    logic                  dropped;
    logic [EW-1:0]         head;
    logic [ATTR_WIDTH-1:0] invalid_attr;

    pu_fifo_mem #(
        .WIDTH      (EW),
        .DEPTH      (FIFO_DEPTH),
        .ADDR_WIDTH (AW)
    ) u_mem (
        .clk   (clk),
        .we    (do_push),
        .waddr (wptr),
        .wdata ({attr_in, data_in}),
        .raddr (rptr),
        .rdata (head)
    );

    // Request qualification; a pop on a full FIFO frees the slot the push needs
    always_comb begin
        is_empty  = (count == '0);
        is_full   = (count == CW'(FIFO_DEPTH));
        do_pop    = signal_oe && !is_empty;
        underflow = signal_oe && is_empty;
        do_push   = signal_wr && (!is_full || do_pop);
        dropped   = signal_wr && is_full && !do_pop;
    end

    // Occupancy after this edge, used for both the count and the registered flags
    always_comb begin
        count_next = count;
        case ({do_push, do_pop})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase
    end

    // Underflow marker: data zero, only the invalid attribute bit set
    always_comb begin
        invalid_attr = '0;
        invalid_attr[ATTR_INVALID] = 1'b1;
    end

    // Pointers, count, flags and the one-cycle bus output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr       <= '0;
            rptr       <= '0;
            count      <= '0;
            data_out   <= '0;
            attr_out   <= '0;
            flag_empty <= 1'b1;
            flag_full  <= 1'b0;
            flag_err   <= 1'b0;
        end else begin
            if (do_push) begin
                wptr <= wptr + AW'(1);
            end
            if (do_pop) begin
                rptr <= rptr + AW'(1);
            end
            count      <= count_next;
            flag_empty <= (count_next == '0);
            flag_full  <= (count_next == CW'(FIFO_DEPTH));
            if (underflow || dropped) begin
                flag_err <= 1'b1;
            end
            if (do_pop) begin
                data_out <= head[DATA_WIDTH-1:0];
                attr_out <= head[EW-1:DATA_WIDTH];
            end else if (underflow) begin
                data_out <= '0;
                attr_out <= invalid_attr;
            end else begin
                data_out <= '0;
                attr_out <= '0;
            end
        end
    end

endmodule

// File: tb/tb_pu_fifo.sv
// tb/tb_pu_fifo.sv - self-checking bench for pu_fifo
module tb_pu_fifo;

    logic        clk;
    logic        rst;
    logic        signal_wr;
    logic        signal_oe;
    logic [15:0] data_in;
    logic [1:0]  attr_in;
    logic [15:0] data_out;
    logic [1:0]  attr_out;
    logic        flag_empty;
    logic        flag_full;
    logic        flag_err;

    int tests;
    int fails;

    typedef struct {
        logic        rst;
        logic        wr;
        logic        oe;
        logic [15:0] din;
        logic [1:0]  ain;
        logic [15:0] edata;
        logic [1:0]  eattr;
        logic        eempty;
        logic        efull;
        logic        eerr;
    } vec_t;

    vec_t vecs[$];

    pu_fifo #(
        .DATA_WIDTH (16),
        .ATTR_WIDTH (2),
        .FIFO_DEPTH (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .signal_wr  (signal_wr),
        .signal_oe  (signal_oe),
        .data_in    (data_in),
        .attr_in    (attr_in),
        .data_out   (data_out),
        .attr_out   (attr_out),
        .flag_empty (flag_empty),
        .flag_full  (flag_full),
        .flag_err   (flag_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mkv(input logic r, input logic w, input logic o,
                                 input logic [15:0] d, input logic [1:0] a,
                                 input logic [15:0] ed, input logic [1:0] ea,
                                 input logic ee, input logic ef, input logic eerr);
        vec_t v;
        v.rst = r; v.wr = w; v.oe = o; v.din = d; v.ain = a;
        v.edata = ed; v.eattr = ea; v.eempty = ee; v.efull = ef; v.eerr = eerr;
        return v;
    endfunction

    task automatic drive(input logic r, input logic w, input logic o,
                         input logic [15:0] d, input logic [1:0] a);
        rst       = r;
        signal_wr = w;
        signal_oe = o;
        data_in   = d;
        attr_in   = a;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [15:0] ed, input logic [1:0] ea,
                         input logic ee, input logic ef, input logic eerr);
        tests++;
        if ({data_out, attr_out, flag_empty, flag_full, flag_err} !== {ed, ea, ee, ef, eerr}) begin
            fails++;
            $display("FAIL %s: got data=%h attr=%h empty=%b full=%b err=%b, expected data=%h attr=%h empty=%b full=%b err=%b",
                     name, data_out, attr_out, flag_empty, flag_full, flag_err, ed, ea, ee, ef, eerr);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b1; signal_wr = 1'b0; signal_oe = 1'b0; data_in = '0; attr_in = '0;

        //            rst wr oe din      ain    edata    eattr  emp full err
        vecs.push_back(mkv(1, 0, 0, 16'h0000, 2'd0, 16'h0000, 2'd0, 1, 0, 0)); // reset
        vecs.push_back(mkv(0, 0, 0, 16'h0000, 2'd0, 16'h0000, 2'd0, 1, 0, 0)); // idle x3
        vecs.push_back(mkv(0, 0, 0, 16'h0000, 2'd0, 16'h0000, 2'd0, 1, 0, 0));
        vecs.push_back(mkv(0, 0, 0, 16'h0000, 2'd0, 16'h0000, 2'd0, 1, 0, 0));
        vecs.push_back(mkv(0, 1, 0, 16'h0002, 2'd0, 16'h0000, 2'd0, 0, 0, 0)); // push x3
        vecs.push_back(mkv(0, 1, 0, 16'h7fff, 2'd0, 16'h0000, 2'd0, 0, 0, 0));
        vecs.push_back(mkv(0, 1, 0, 16'h8000, 2'd2, 16'h0000, 2'd0, 0, 0, 0));
        vecs.push_back(mkv(0, 0, 1, 16'h0000, 2'd0, 16'h0002, 2'd0, 0, 0, 0)); // pop x3
        vecs.push_back(mkv(0, 0, 1, 16'h0000, 2'd0, 16'h7fff, 2'd0, 0, 0, 0));
        vecs.push_back(mkv(0, 0, 1, 16'h0000, 2'd0, 16'h8000, 2'd2, 1, 0, 0));
        vecs.push_back(mkv(0, 0, 0, 16'h0000, 2'd0, 16'h0000, 2'd0, 1, 0, 0)); // bus released
        vecs.push_back(mkv(0, 1, 0, 16'h1234, 2'd0, 16'h0000, 2'd0, 0, 0, 0)); // push then
        vecs.push_back(mkv(0, 0, 1, 16'h0000, 2'd0, 16'h1234, 2'd0, 1, 0, 0)); // pop next edge
        vecs.push_back(mkv(0, 0, 0, 16'h0000, 2'd0, 16'h0000, 2'd0, 1, 0, 0));
        vecs.push_back(mkv(0, 1, 1, 16'h5555, 2'd1, 16'h0000, 2'd1, 0, 0, 1)); // push+pop on empty
        vecs.push_back(mkv(0, 0, 1, 16'h0000, 2'd0, 16'h5555, 2'd1, 1, 0, 1)); // stored word
        vecs.push_back(mkv(0, 0, 1, 16'h0000, 2'd0, 16'h0000, 2'd1, 1, 0, 1)); // underflow again
        vecs.push_back(mkv(0, 0, 0, 16'h0000, 2'd0, 16'h0000, 2'd0, 1, 0, 1)); // err sticky
        vecs.push_back(mkv(1, 1, 1, 16'hbeef, 2'd3, 16'h0000, 2'd0, 1, 0, 0)); // reset clears err

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].wr, vecs[i].oe, vecs[i].din, vecs[i].ain);
            check($sformatf("vec%0d", i), vecs[i].edata, vecs[i].eattr,
                  vecs[i].eempty, vecs[i].efull, vecs[i].eerr);
        end

        // Fill to full, simultaneous push/pop at full, dropped push, drain
        for (int i = 0; i < 8; i++) begin
            drive(0, 1, 0, 16'h0010 + 16'(i), 2'd0);
            check($sformatf("fill%0d", i), 16'h0000, 2'd0, 1'b0, (i == 7), 1'b0);
        end
        drive(0, 1, 1, 16'h0aaa, 2'd0);
        check("full_push_pop", 16'h0010, 2'd0, 1'b0, 1'b1, 1'b0);
        drive(0, 1, 0, 16'h00ff, 2'd0);
        check("drop_when_full", 16'h0000, 2'd0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 8; i++) begin
            logic [15:0] exp_d;
            exp_d = (i == 7) ? 16'h0aaa : 16'h0011 + 16'(i);
            drive(0, 0, 1, 16'h0000, 2'd0);
            check($sformatf("drain%0d", i), exp_d, 2'd0, (i == 7), 1'b0, 1'b1);
        end
        drive(0, 0, 0, 16'h0000, 2'd0);
        check("drain_idle", 16'h0000, 2'd0, 1'b1, 1'b0, 1'b1);

        // Reset mid-operation discards entries; next pop underflows
        drive(1, 0, 0, 16'h0000, 2'd0);
        check("reset2", 16'h0000, 2'd0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 0, 16'h0100 + 16'(i), 2'd0);
        end
        check("four_pushed", 16'h0000, 2'd0, 1'b0, 1'b0, 1'b0);
        drive(1, 0, 1, 16'h0000, 2'd0);
        check("reset_with_pop", 16'h0000, 2'd0, 1'b1, 1'b0, 1'b0);
        drive(0, 0, 1, 16'h0000, 2'd0);
        check("pop_after_reset", 16'h0000, 2'd1, 1'b1, 1'b0, 1'b1);
        drive(0, 0, 0, 16'h0000, 2'd0);
        check("underflow_one_cycle", 16'h0000, 2'd0, 1'b1, 1'b0, 1'b1);

        // Overflow attribute preserved verbatim through the FIFO
        drive(0, 1, 0, 16'h8000, 2'd2);
        drive(0, 0, 1, 16'h0000, 2'd0);
        check("overflow_attr", 16'h8000, 2'd2, 1'b1, 1'b0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
